// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle control unit: fetch, decode, execute, memory, write-back
// Owns pc and ir; all control outputs are registered and decoded from the next state and ir.
module cpu_ctrl #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     ir,
  output logic [PC_W-1:0] pc,
  output logic            in_read,
  output logic            in_write,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  input  logic            alu_zero,
  output logic            wb_sel,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [2:0]      state,
  output logic            halted,
  output logic [15:0]     instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          st, nxt_st;
  logic [15:0]     nxt_ir;
  logic [PC_W-1:0] nxt_pc;
  logic            retire;
  logic [3:0]      opcode;

  assign opcode    = ir[15:12];
  assign state     = st;
  assign imem_addr = pc;

  // Moore output decode, evaluated on the state/ir that will be current after the edge.
  function automatic logic [11:0] outs(input state_t s, input logic [15:0] i);
    logic       req, rd, wr, imm, wbs, dreq, dwe, hlt;
    logic [3:0] op, aop;
    req = 1'b0; rd = 1'b0; wr = 1'b0; imm = 1'b0;
    wbs = 1'b0; dreq = 1'b0; dwe = 1'b0; hlt = 1'b0;
    aop = 4'd0;
    op  = i[15:12];
    case (s)
      S_FETCH:  req = 1'b1;
      S_DECODE: rd = 1'b1;
      S_EXEC: begin
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3: aop = op;
          4'h4: imm = 1'b1;
          4'h7: aop = 4'd1;
          default: aop = 4'd0;
        endcase
      end
      S_MEM: begin
        dreq = 1'b1;
        dwe  = (op == 4'h6);
      end
      S_WB: begin
        wr  = 1'b1;
        wbs = (op == 4'h5);
      end
      S_HALT:  hlt = 1'b1;
      default: req = 1'b0;
    endcase
    return {req, rd, wr, aop, imm, wbs, dreq, dwe, hlt};
  endfunction

  always_comb begin
    nxt_st = st;
    nxt_pc = pc;
    nxt_ir = ir;
    retire = 1'b0;
    case (st)
      S_FETCH: begin
        if (imem_ack) begin
          nxt_ir = imem_data;
          nxt_st = S_DECODE;
        end
      end
      S_DECODE: nxt_st = S_EXEC;
      S_EXEC: begin
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4: nxt_st = S_WB;
          4'h5, 4'h6: nxt_st = S_MEM;
          4'h7: begin
            if (alu_zero)
              nxt_pc = pc + PC_W'(1) + PC_W'($signed(ir[11:8]));
            else
              nxt_pc = pc + PC_W'(1);
            nxt_st = S_FETCH;
            retire = 1'b1;
          end
          4'h8: begin
            nxt_pc = PC_W'(ir[11:0]);
            nxt_st = S_FETCH;
            retire = 1'b1;
          end
          4'hF: begin
            nxt_st = S_HALT;
            retire = 1'b1;
          end
          default: begin
            nxt_pc = pc + PC_W'(1);
            nxt_st = S_FETCH;
            retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (opcode == 4'h6) begin
            nxt_pc = pc + PC_W'(1);
            nxt_st = S_FETCH;
            retire = 1'b1;
          end else begin
            nxt_st = S_WB;
          end
        end
      end
      S_WB: begin
        nxt_pc = pc + PC_W'(1);
        nxt_st = S_FETCH;
        retire = 1'b1;
      end
      S_HALT:  nxt_st = S_HALT;
      default: nxt_st = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_FETCH;
      pc          <= '0;
      ir          <= 16'h0000;
      instr_count <= 16'h0000;
      {imem_req, in_read, in_write, alu_op, alu_src_imm, wb_sel,
       dmem_req, dmem_we, halted} <= outs(S_FETCH, 16'h0000);
    end else begin
      st <= nxt_st;
      pc <= nxt_pc;
      ir <= nxt_ir;
      if (retire)
        instr_count <= instr_count + 16'd1;
      {imem_req, in_read, in_write, alu_op, alu_src_imm, wb_sel,
       dmem_req, dmem_we, halted} <= outs(nxt_st, nxt_ir);
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - scoreboard bench for cpu_ctrl with directed instruction vectors
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_data, ir, instr_count;
  logic        in_read, in_write, alu_src_imm, alu_zero, wb_sel;
  logic        dmem_req, dmem_we, dmem_ack, halted;
  logic [3:0]  alu_op;
  logic [2:0]  state;

  cpu_ctrl #(.PC_W(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir), .pc(pc), .in_read(in_read), .in_write(in_write),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_zero(alu_zero), .wb_sel(wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .state(state), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // flags: {imem_req, in_read, in_write, alu_op[3:0], alu_src_imm, wb_sel, dmem_req, dmem_we, halted}
  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  pc;
    logic [7:0]  addr;
    logic [15:0] ic;
    logic [15:0] ir;
    logic [11:0] fl;
  } snap_t;

  snap_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;

  function automatic snap_t sn(input logic [2:0] s, input logic [7:0] p, input logic [15:0] c,
                               input logic [15:0] i, input logic [11:0] f);
    snap_t r;
    r.st = s; r.pc = p; r.addr = p; r.ic = c; r.ir = i; r.fl = f;
    return r;
  endfunction

  always @(negedge clk) begin
    snap_t e, a;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = sn(state, pc, instr_count, ir,
             {imem_req, in_read, in_write, alu_op, alu_src_imm, wb_sel, dmem_req, dmem_we, halted});
      a.addr = imem_addr;
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL cyc%0d: got st=%0d pc=%h addr=%h ic=%0d ir=%h fl=%h, want st=%0d pc=%h addr=%h ic=%0d ir=%h fl=%h",
                    cyc, a.st, a.pc, a.addr, a.ic, a.ir, a.fl, e.st, e.pc, e.addr, e.ic, e.ir, e.fl);
    end
  end

  task automatic step(input snap_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic f_idle(input logic [7:0] p, input logic [15:0] c, input logic [15:0] i);
    step(sn(3'd0, p, c, i, 12'h800));
  endtask

  task automatic fd(input logic [7:0] p, input logic [15:0] c, input logic [15:0] old_ir,
                    input logic [15:0] instr);
    imem_ack = 1'b1; imem_data = instr;
    step(sn(3'd0, p, c, old_ir, 12'h800));
    imem_ack = 1'b0; imem_data = 16'hDEAD;
    step(sn(3'd1, p, c, instr, 12'h400));
  endtask

  task automatic ex(input logic [7:0] p, input logic [15:0] c, input logic [15:0] i,
                    input logic [3:0] op, input logic imm);
    step(sn(3'd2, p, c, i, {3'b000, op, imm, 4'b0000}));
  endtask

  task automatic mm(input logic [7:0] p, input logic [15:0] c, input logic [15:0] i, input logic we);
    step(sn(3'd3, p, c, i, {9'b0, 1'b1, we, 1'b0}));
  endtask

  task automatic wb(input logic [7:0] p, input logic [15:0] c, input logic [15:0] i, input logic sel);
    step(sn(3'd4, p, c, i, {8'h20, sel, 3'b000}));
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = 16'h0; alu_zero = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) f_idle(8'h00, 16'd0, 16'h0000);

    // ADD, then one idle fetch cycle
    fd(8'h00, 16'd0, 16'h0000, 16'h0123);
    ex(8'h00, 16'd0, 16'h0123, 4'd0, 1'b0);
    wb(8'h00, 16'd0, 16'h0123, 1'b0);
    f_idle(8'h01, 16'd1, 16'h0123);

    // LW with three wait cycles on dmem_ack
    fd(8'h01, 16'd1, 16'h0123, 16'h5210);
    ex(8'h01, 16'd1, 16'h5210, 4'd0, 1'b0);
    repeat (3) mm(8'h01, 16'd1, 16'h5210, 1'b0);
    dmem_ack = 1'b1;
    mm(8'h01, 16'd1, 16'h5210, 1'b0);
    dmem_ack = 1'b0;
    wb(8'h01, 16'd1, 16'h5210, 1'b1);

    // JMP 5, BEQ taken back to 4, NOP, BEQ not taken
    fd(8'h02, 16'd2, 16'h5210, 16'h8005);
    ex(8'h02, 16'd2, 16'h8005, 4'd0, 1'b0);
    fd(8'h05, 16'd3, 16'h8005, 16'h7E12);
    alu_zero = 1'b1;
    ex(8'h05, 16'd3, 16'h7E12, 4'd1, 1'b0);
    alu_zero = 1'b0;
    fd(8'h04, 16'd4, 16'h7E12, 16'h9000);
    ex(8'h04, 16'd4, 16'h9000, 4'd0, 1'b0);
    fd(8'h05, 16'd5, 16'h9000, 16'h7E12);
    ex(8'h05, 16'd5, 16'h7E12, 4'd1, 1'b0);

    // pc wrap: JMP 0xFF then NOP
    fd(8'h06, 16'd6, 16'h7E12, 16'h80FF);
    ex(8'h06, 16'd6, 16'h80FF, 4'd0, 1'b0);
    fd(8'hFF, 16'd7, 16'h80FF, 16'h9000);
    ex(8'hFF, 16'd7, 16'h9000, 4'd0, 1'b0);

    // ADDI, zero-wait SW, JMP 0xAB, OR
    fd(8'h00, 16'd8, 16'h9000, 16'h4305);
    ex(8'h00, 16'd8, 16'h4305, 4'd0, 1'b1);
    wb(8'h00, 16'd8, 16'h4305, 1'b0);
    fd(8'h01, 16'd9, 16'h4305, 16'h6210);
    ex(8'h01, 16'd9, 16'h6210, 4'd0, 1'b0);
    dmem_ack = 1'b1;
    mm(8'h01, 16'd9, 16'h6210, 1'b1);
    dmem_ack = 1'b0;
    fd(8'h02, 16'd10, 16'h6210, 16'h80AB);
    ex(8'h02, 16'd10, 16'h80AB, 4'd0, 1'b0);
    fd(8'hAB, 16'd11, 16'h80AB, 16'h3456);
    ex(8'hAB, 16'd11, 16'h3456, 4'd3, 1'b0);
    wb(8'hAB, 16'd11, 16'h3456, 1'b0);

    // HALT ignores a fetch ack, only rst leaves it
    fd(8'hAC, 16'd12, 16'h3456, 16'hF000);
    ex(8'hAC, 16'd12, 16'hF000, 4'd0, 1'b0);
    imem_ack = 1'b1;
    repeat (3) step(sn(3'd5, 8'hAC, 16'd13, 16'hF000, 12'h001));
    rst = 1'b1;
    step(sn(3'd5, 8'hAC, 16'd13, 16'hF000, 12'h001));
    rst = 1'b0; imem_ack = 1'b0;
    f_idle(8'h00, 16'd0, 16'h0000);

    // reset together with dmem_ack during an SW wait
    fd(8'h00, 16'd0, 16'h0000, 16'h6000);
    ex(8'h00, 16'd0, 16'h6000, 4'd0, 1'b0);
    mm(8'h00, 16'd0, 16'h6000, 1'b1);
    rst = 1'b1; dmem_ack = 1'b1;
    mm(8'h00, 16'd0, 16'h6000, 1'b1);
    rst = 1'b0; dmem_ack = 1'b0;
    f_idle(8'h00, 16'd0, 16'h0000);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit for the 16-bit processor core. It owns the program counter and the instruction register, fetches instructions over a request/acknowledge handshake, and drives the decode stage's `palavra` input from its instruction register. It sequences every instruction through fetch, decode, execute, memory and write-back, generating the register-file read/write enables, ALU controls and data-memory handshake.

## Interface
- `PC_W`, default 8: program counter and instruction address width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: instruction fetch request; held high until acknowledged.
- `imem_addr` out PC_W: fetch address, equal to `pc`.
- `imem_ack` in 1: fetch acknowledge; `imem_data` valid in the same cycle.
- `imem_data` in 16: fetched instruction word.
- `ir` out 16: instruction register; feeds the decode stage's `palavra`.
- `pc` out PC_W: current program counter.
- `in_read` out 1: register-file read enable.
- `in_write` out 1: register-file write enable.
- `alu_op` out 4: ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR.
- `alu_src_imm` out 1: selects `ir[11:8]` zero-extended as ALU operand B.
- `alu_zero` in 1: ALU result-is-zero flag, sampled in EXEC.
- `wb_sel` out 1: write-back source; 1 selects memory data, 0 selects the ALU result.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write; valid while `dmem_req` is high.
- `dmem_ack` in 1: data memory acknowledge.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- `halted` out 1: high in HALT.
- `instr_count` out 16: retired-instruction counter, wraps modulo 2^16.

## Operation
- Opcode is `ir[15:12]`:
  - 0–3: R-type ALU ops.
  - 4: ADDI.
  - 5: LW.
  - 6: SW.
  - 7: BEQ.
  - 8: JMP.
  - F: HALT.
  - 9–E: NOP.
- **FETCH:** `imem_req`=1. On `imem_ack`: `ir`<=`imem_data`, go to DECODE. Without ack, stay in FETCH.
- **DECODE:** `in_read`=1 for exactly one cycle, then go to EXEC.
- **EXEC:** `alu_op`/`alu_src_imm` are driven from `ir`. Action by opcode:
  - 0–3: go to WB.
  - 4: `alu_op`=0, `alu_src_imm`=1; go to WB.
  - 5/6: `alu_op`=0 (address compute); go to MEM.
  - 7: `alu_op`=1. If `alu_zero`, `pc`<=`pc`+1+sext(`ir[11:8]`); else `pc`<=`pc`+1. Go to FETCH.
  - 8: `pc`<=`ir[PC_W-1:0]` (`ir[11:0]` truncated or zero-extended to PC_W); go to FETCH.
  - F: go to HALT; `pc` is unchanged.
  - 9–E: `pc`<=`pc`+1; go to FETCH.
- **MEM:** `dmem_req`=1, `dmem_we`=(opcode==6), `alu_op`=0, held until `dmem_ack`.
  - On ack, LW goes to WB.
  - On ack, SW sets `pc`<=`pc`+1 and goes to FETCH.
- **WB:** `in_write`=1 for one cycle, `wb_sel`=(opcode==5), `pc`<=`pc`+1, then go to FETCH.
- **HALT:** all request and enable outputs are 0. Stays in HALT until `rst`.
- **PC arithmetic:** modulo 2^PC_W. Overflow past the maximum wraps to 0. Branch offsets are 4-bit two's complement (range −8..+7).
- **`instr_count`:** increments by 1 on every transition into FETCH from EXEC, MEM or WB. Increments on the HALT transition too, so HALT counts as retired.
- **Outside listed states:** `alu_op`=0 and `alu_src_imm`=0. `wb_sel`=0 outside WB.

## Timing
- **Reset values:**
  - `state`=FETCH, `pc`=0, `ir`=0, `instr_count`=0.
  - `imem_req`, `in_read`, `in_write`, `alu_src_imm`, `wb_sel`, `dmem_req`, `dmem_we`, `halted`: all 0 in the cycle after the `rst` edge, except `imem_req`, which is 1 (state is FETCH).
- **`rst` has priority** over every transition. Asserted mid-handshake, it drops `dmem_req` and returns to FETCH at `pc`=0 on the next edge. A pending ack in that same cycle is ignored.
- **Outputs are Moore:** decoded from `state` and `ir`. The only inputs sampled are `imem_ack`/`imem_data`, `dmem_ack` and `alu_zero`.
- **Acknowledge in the first cycle:** an ack arriving in the same cycle as the first request cycle completes the transfer, so there is no minimum wait.
- **Latency with zero-wait acks:**
  - R-type/ADDI/LW: 4 cycles (LW 5, including MEM).
  - SW: 4 cycles.
  - BEQ/JMP/NOP: 3 cycles.
  - Each acknowledge wait cycle adds 1.
- **`ir` stability:** `ir` changes only on the FETCH ack edge, so it is stable from DECODE through WB.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release with `imem_ack`=0 -> `state`=0, `pc`=0, `imem_req`=1, `instr_count`=0, all other enables 0, held indefinitely.
- **ADD:** `imem_data`=0x0123 acked immediately -> DECODE with `in_read`=1, EXEC with `alu_op`=0, WB with `in_write`=1 and `wb_sel`=0. Next FETCH has `pc`=1, `instr_count`=1, 4 cycles total.
- **LW:** 0x5210 with `dmem_ack` delayed 3 cycles -> `dmem_req`=1 and `dmem_we`=0 for 4 cycles, then WB with `wb_sel`=1; `pc` advances by 1.
- **BEQ:** at `pc`=5, `ir`=0x7E12 (offset −2), `alu_zero`=1 -> `pc`=4. With `alu_zero`=0 -> `pc`=6. PC_W=8, `pc`=255, NOP -> `pc`=0.
- **JMP and HALT:** JMP 0x80AB -> `pc`=0xAB. HALT 0xF000 -> `halted`=1, no further `imem_req`, `pc` unchanged. `rst` -> FETCH at `pc`=0.
- **Reset mid-MEM:** during an SW wait, assert `rst` together with `dmem_ack` -> next cycle `dmem_req`=0, `state`=FETCH, `instr_count`=0.
